// File: rtl/input_port_buffer.sv
// input_port_buffer: per-port ingress stage of the 8x8 router.
// Parses the header word of each line-side frame for its destination port,
// drops frames addressed beyond port 7, and buffers payload words tagged with
// their destination in a show-ahead FIFO that the switch fabric pops.
//
// Ports:
//   clock, reset         sole clock; synchronous active-high reset
//   din, valid_i         line-side word and its qualifier
//   sof_i, eof_i         header / last-word markers for the current word
//   ready_o              din is consumed on a cycle with valid_i & ready_o
//   rd_en                fabric pops the head entry
//   fifo_data_out        head payload word, 0 when empty
//   fifo_empty           no entry stored
//   addr_from_input      destination of the head word, 0 when empty
//   drop_count           frames dropped for invalid destination, saturating
module input_port_buffer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DEPTH      = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  valid_i,
  input  logic                  sof_i,
  input  logic                  eof_i,
  output logic                  ready_o,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] fifo_data_out,
  output logic                  fifo_empty,
  output logic [ADDR_WIDTH-1:0] addr_from_input,
  output logic [7:0]            drop_count
);

  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned ENTRY_W = ADDR_WIDTH + DATA_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PAYLOAD,
    S_DROP
  } state_t;

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   cur_addr, cur_addr_nxt;
  logic [ENTRY_W-1:0]      mem [DEPTH];
  logic [PTR_W-1:0]        wr_ptr, rd_ptr;
  logic [CNT_W-1:0]        count;
  logic                    full_c;
  logic                    wr_c;
  logic                    rd_c;
  logic                    drop_inc_c;

  // Full comes from the registered count only, so ready_o never depends on rd_en.
  assign full_c = (count == CNT_W'(DEPTH));
  assign rd_c   = rd_en && (count != '0);

  // Framing FSM: header parsing, payload write enable and drop detection.
  always_comb begin
    state_nxt    = state;
    cur_addr_nxt = cur_addr;
    ready_o      = 1'b1;
    wr_c         = 1'b0;
    drop_inc_c   = 1'b0;

    if (state == S_PAYLOAD) begin
      ready_o = !full_c;
    end

    if (valid_i && ready_o) begin
      if (sof_i) begin
        // Any sof word is a new header; an open frame is simply truncated.
        cur_addr_nxt = din[ADDR_WIDTH-1:0];
        if (din[3]) begin
          drop_inc_c = 1'b1;
          state_nxt  = eof_i ? S_IDLE : S_DROP;
        end else begin
          state_nxt  = eof_i ? S_IDLE : S_PAYLOAD;
        end
      end else begin
        case (state)
          S_PAYLOAD: begin
            wr_c = 1'b1;
            if (eof_i) state_nxt = S_IDLE;
          end
          S_DROP: begin
            if (eof_i) state_nxt = S_IDLE;
          end
          default: begin
            // Stray word outside a frame: discarded.
          end
        endcase
      end
    end
  end

  // Control state, pointers, occupancy and drop counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_IDLE;
      cur_addr   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      drop_count <= '0;
    end else begin
      state    <= state_nxt;
      cur_addr <= cur_addr_nxt;
      if (wr_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_c) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_c, rd_c})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (drop_inc_c && (drop_count != 8'hFF)) drop_count <= drop_count + 8'd1;
    end
  end

  // Entry storage; contents are invalidated by the cleared count, not by reset.
  always_ff @(posedge clock) begin
    if (wr_c) mem[wr_ptr] <= {cur_addr, din};
  end

  // Show-ahead head, forced to zero while empty.
  assign fifo_empty      = (count == '0);
  assign fifo_data_out   = fifo_empty ? '0 : mem[rd_ptr][DATA_WIDTH-1:0];
  assign addr_from_input = fifo_empty ? '0 : mem[rd_ptr][ENTRY_W-1:DATA_WIDTH];

endmodule

// File: tb/tb_input_port_buffer.sv
module tb_input_port_buffer;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 4;
  localparam int unsigned DEPTH = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] din = '0;
  logic          valid_i = 1'b0;
  logic          sof_i = 1'b0;
  logic          eof_i = 1'b0;
  logic          ready_o;
  logic          rd_en = 1'b0;
  logic [DW-1:0] fifo_data_out;
  logic          fifo_empty;
  logic [AW-1:0] addr_from_input;
  logic [7:0]    drop_count;

  input_port_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .din(din), .valid_i(valid_i),
    .sof_i(sof_i), .eof_i(eof_i), .ready_o(ready_o), .rd_en(rd_en),
    .fifo_data_out(fifo_data_out), .fifo_empty(fifo_empty),
    .addr_from_input(addr_from_input), .drop_count(drop_count)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int errors  = 0;

  // Reference model: expected stored entries plus frame-level parser state.
  logic [AW+DW-1:0] sb[$];
  bit               m_in_frame = 0;
  bit               m_ok = 0;
  logic [AW-1:0]    m_addr = '0;
  int               m_drops = 0;
  bit               mon_en = 0;
  bit               rand_done = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit exp_ready();
    return !(m_in_frame && m_ok && (sb.size() >= DEPTH));
  endfunction

  function automatic void model_accept(input logic [DW-1:0] w, input bit s, input bit e);
    if (s) begin
      m_addr     = w[AW-1:0];
      m_ok       = (int'(w[AW-1:0]) < 8);
      if (!m_ok && m_drops < 255) m_drops++;
      m_in_frame = !e;
    end else if (m_in_frame) begin
      if (m_ok) sb.push_back({m_addr, w});
      if (e) m_in_frame = 0;
    end
  endfunction

  // Offers one word and holds it until accepted; entered and left at posedge+1.
  task automatic send(input logic [DW-1:0] w, input bit s, input bit e);
    bit acc;
    din = w; valid_i = 1'b1; sof_i = s; eof_i = e;
    for (int t = 0; ; t++) begin
      @(negedge clock);
      check("ready_o", 64'(ready_o), 64'(exp_ready()));
      acc = ready_o;
      @(posedge clock);
      if (acc) model_accept(w, s, e);
      #1;
      if (acc) break;
      if (t >= 200) begin
        vectors++; errors++;
        $display("FAIL send_timeout: word %0h not accepted within 200 cycles", w);
        break;
      end
    end
    valid_i = 1'b0; sof_i = 1'b0; eof_i = 1'b0; din = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1; rd_en = 1'b0; valid_i = 1'b0; sof_i = 1'b0; eof_i = 1'b0;
    repeat (n) begin
      @(posedge clock); #1;
      sb.delete(); m_in_frame = 0; m_ok = 0; m_drops = 0;
    end
    reset = 1'b0;
  endtask

  task automatic check_status(input string tag);
    @(negedge clock);
    check({tag, "_drop_count"}, 64'(drop_count), 64'(m_drops));
    check({tag, "_ready"}, 64'(ready_o), 64'(exp_ready()));
    check({tag, "_empty"}, 64'(fifo_empty), 64'(sb.size() == 0));
    @(posedge clock); #1;
  endtask

  task automatic drain();
    bit emptied = 0;
    rd_en = 1'b1;
    for (int t = 0; t < 100; t++) begin
      @(negedge clock);
      if (fifo_empty) begin emptied = 1; break; end
    end
    check("drain_empty", 64'(emptied), 64'(1));
    @(posedge clock); #1;
    rd_en = 1'b0;
  endtask

  // Monitor: compares the presented head with the scoreboard every cycle.
  initial begin
    bit pop;
    wait (mon_en);
    forever begin
      @(negedge clock);
      pop = 0;
      if (!fifo_empty) begin
        if (sb.size() == 0) begin
          vectors++; errors++;
          $display("FAIL head_unexpected: got %0h:%0h expected empty", addr_from_input, fifo_data_out);
        end else begin
          check("head", {28'h0, addr_from_input, fifo_data_out}, 64'(sb[0]));
        end
        pop = rd_en;
      end else begin
        check("empty_data", 64'(fifo_data_out), 64'(0));
        check("empty_addr", 64'(addr_from_input), 64'(0));
        check("empty_vs_model", 64'(sb.size()), 64'(0));
      end
      @(posedge clock);
      if (pop && sb.size() > 0) void'(sb.pop_front());
    end
  end

  initial begin
    logic [DW-1:0] w;
    int            addr, len;

    // Reset
    do_reset(2);
    @(negedge clock);
    check("rst_empty", 64'(fifo_empty), 64'(1));
    check("rst_ready", 64'(ready_o), 64'(1));
    check("rst_data", 64'(fifo_data_out), 64'(0));
    check("rst_addr", 64'(addr_from_input), 64'(0));
    check("rst_drops", 64'(drop_count), 64'(0));
    @(posedge clock); #1;
    mon_en = 1;

    // Basic frame
    send(32'h5, 1, 0);
    send(32'hA1, 0, 0);
    send(32'hA2, 0, 0);
    send(32'hA3, 0, 1);
    idle(2);
    drain();

    // Fill and wrap: 20 words, the last 4 held until reads free space
    send(32'h2, 1, 0);
    for (int i = 1; i <= 16; i++) send(32'h100 + 32'(i), 0, 0);
    @(negedge clock);
    check("full_ready_low", 64'(ready_o), 64'(0));
    check("full_not_empty", 64'(fifo_empty), 64'(0));
    @(posedge clock); #1;
    fork
      begin
        for (int i = 17; i <= 20; i++) send(32'h100 + 32'(i), 0, i == 20);
      end
      begin
        idle(2);
        rd_en = 1'b1;
        idle(22);
        rd_en = 1'b0;
      end
    join
    drain();
    check_status("fill");

    // Invalid destination followed by a valid frame
    send(32'h0000000B, 1, 0);
    send(32'hD1, 0, 0);
    send(32'hD2, 0, 0);
    send(32'hD3, 0, 1);
    send(32'h1, 1, 0);
    send(32'hE1, 0, 1);
    check_status("invalid");
    drain();

    // Truncation and stray words
    send(32'h4, 1, 0);
    send(32'hB1, 0, 0);
    send(32'h6, 1, 0);
    send(32'hC1, 0, 1);
    send(32'h55, 0, 0);
    send(32'h66, 0, 1);
    send(32'h0, 0, 0);
    drain();

    // Zero-valued payload and header-only frames
    send(32'h7, 1, 1);
    send(32'h9, 1, 1);
    send(32'h3, 1, 0);
    send(32'h0, 0, 1);
    idle(1);
    drain();
    check_status("hdr_only");

    // Reset mid-frame
    send(32'h3, 1, 0);
    send(32'hF1, 0, 0);
    send(32'hF2, 0, 0);
    do_reset(1);
    check_status("mid_reset");
    send(32'h77, 0, 1);
    idle(2);
    check_status("post_reset");

    // Randomized frames with random popping
    fork
      begin
        for (int f = 0; f < 80; f++) begin
          if ($urandom_range(4) == 0) send($urandom, 0, $urandom_range(1) == 1);
          addr = ($urandom_range(3) == 0) ? 8 + int'($urandom_range(7)) : int'($urandom_range(7));
          len  = int'($urandom_range(5));
          w    = ($urandom & 32'hFFFF_FFF0) | 32'(addr);
          send(w, 1, len == 0);
          for (int k = 1; k <= len; k++) begin
            w = ($urandom_range(7) == 0) ? 32'h0 : $urandom;
            send(w, 0, (k == len) && ($urandom_range(5) != 0));
          end
          idle(int'($urandom_range(2)));
        end
        rand_done = 1;
      end
      begin
        while (!rand_done) begin
          rd_en = ($urandom_range(2) != 0);
          @(posedge clock); #1;
        end
        rd_en = 1'b0;
      end
    join
    drain();
    check_status("random");

    // drop_count saturation
    do_reset(1);
    for (int i = 0; i < 260; i++) send(32'h8 + 32'(i % 8), 1, 1);
    check_status("saturate");
    check("drop_sat", 64'(drop_count), 64'(255));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/input_port_buffer.md
# input_port_buffer

Per-port ingress stage of the 8x8 router, one instance per input port, sitting directly upstream of `switch_fabric`. It accepts framed 32-bit words from the line side and parses the header word to obtain the destination port. Payload words are buffered together with that destination in a show-ahead FIFO. It presents `fifo_data_out`, `fifo_empty` and `addr_from_input` to the fabric, which pops the buffer with `rd_en`.

## Interface
- `DATA_WIDTH`, 32, payload word width
- `ADDR_WIDTH`, 4, destination field width; the fabric addresses ports 0–7
- `DEPTH`, 16, FIFO entries; must be a power of 2, minimum 4
- `clock`  in  1  sole clock; all state updates on its rising edge
- `reset`  in  1  synchronous, active-high reset
- `din`  in  DATA_WIDTH  line-side word
- `valid_i`  in  1  `din` qualifier
- `sof_i`  in  1  start of frame; marks the header word
- `eof_i`  in  1  end of frame; marks the last word
- `ready_o`  out  1  block consumes `din` this cycle when `valid_i & ready_o`
- `rd_en`  in  1  fabric pops the head entry
- `fifo_data_out`  out  DATA_WIDTH  head payload word (show-ahead)
- `fifo_empty`  out  1  no entry stored
- `addr_from_input`  out  ADDR_WIDTH  destination of the head word
- `drop_count`  out  8  frames dropped for invalid destination; saturates at 255

## Operation
- **Storage.** FIFO entries are `{addr[ADDR_WIDTH-1:0], data[DATA_WIDTH-1:0]}`. Header words are never stored.
- **Pointers and occupancy.** Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH. Occupancy count is log2(DEPTH)+1 bits.
- **Transfer condition.** A word transfers only when `valid_i & ready_o`. When `valid_i & !ready_o`, upstream holds `din` and the control bits stable.
- **`ready_o` logic:**
  - high in IDLE and DROP;
  - in PAYLOAD, `ready_o = !full`, computed from registered count only;
  - no write-through when a read occurs in the same cycle.
- **FSM states: IDLE, PAYLOAD, DROP.**
- **IDLE:**
  - transfer with `sof_i`: latch `cur_addr = din[ADDR_WIDTH-1:0]`.
    - If `din[3]` is set (destination ≥ 8): go to DROP, increment `drop_count`.
    - Otherwise go to PAYLOAD.
  - header with `sof_i & eof_i`: header-only frame; apply the same address check, stay in IDLE, store nothing. If invalid, still increment `drop_count`.
  - transfer without `sof_i`: stray word, discarded, no count.
- **PAYLOAD:**
  - transfer without `sof_i`: write `{cur_addr, din}`; on `eof_i` return to IDLE.
  - transfer with `sof_i`: the current frame is truncated (words already written stay) and the word is processed as a new header, as in IDLE.
- **DROP:**
  - transfers are discarded;
  - on `eof_i` go to IDLE;
  - `sof_i` is processed as a new header, as in IDLE.
- **Read side:**
  - `rd_en & !fifo_empty` advances the read pointer;
  - `rd_en` while empty is ignored;
  - simultaneous read and write leaves the count unchanged.
- **Outputs when empty:** `fifo_data_out = 0` and `addr_from_input = 0`. A zero-valued payload word is stored and presented unchanged.
- **Reset (asserted at a clock edge), including mid-frame:**
  - FIFO contents are invalidated;
  - pointers and count cleared;
  - state returns to IDLE;
  - `drop_count = 0`;
  - outputs: `fifo_empty = 1`, `ready_o = 1`, `fifo_data_out = 0`, `addr_from_input = 0`.
  - A partially received frame is lost. Words arriving after reset without `sof_i` are stray.

## Timing
- **Write latency.** A payload word accepted at edge N into an empty FIFO appears on `fifo_data_out`/`addr_from_input`, with `fifo_empty = 0`, in the cycle after edge N. There is no combinational `din`→output path.
- **Read.** `rd_en` is sampled at edge N; the next entry (or empty) is visible after edge N.
- **Throughput.** One word per cycle in and one per cycle out sustained, including when full with a simultaneous read. Full status, and therefore `ready_o`, updates after the edge.
- **Header.** Consumes one cycle and produces no FIFO write.
- **`drop_count`.** Updates on the edge that accepts the invalid header.

## Test plan
- **Reset.** Reset for 2 cycles, then release → `fifo_empty = 1`, `ready_o = 1`, `fifo_data_out = 0`, `addr_from_input = 0`, `drop_count = 0`.
- **Basic frame.** Header `0x00000005`, payload `0xA1`, `0xA2`, `0xA3` (`eof_i` on `0xA3`), back-to-back → head shows `0xA1`, addr 5, one cycle after its accept. Popping with `rd_en` yields `0xA2`, `0xA3`, then empty with outputs 0.
- **Fill and wrap.** DEPTH=16: send header addr 2 plus 20 payload words with `rd_en` low → `ready_o` drops after the 16th write, and words 17–20 are held by upstream. Raise `rd_en` for 20 cycles → all 20 words read in order with no loss after the pointer wrap.
- **Invalid destination.** Header `0x0000000B`, 3 payload words, then header `0x1` plus 1 word → `drop_count = 1`, only the second frame is stored, addr 1.
- **Truncation and stray words.**
  - Header addr 4, payload `0xB1`, then new header addr 6 with payload `0xC1` + eof → stored `{4,0xB1}` then `{6,0xC1}`.
  - Stray `valid_i` words in IDLE → not stored.
- **Reset mid-frame.** Assert reset after header addr 3 plus 2 payload words → FIFO empty. A following payload word without `sof_i` is discarded.
